mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state,
// captured request attributes and default widths.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } req_src_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request/response and RAM-port signals of the memory arbiter.
// The arbiter uses the slave view; the CPU/RAM environment uses master.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic              dhit;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic              ram_ready;
  logic [DATA_W-1:0] ram_load;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
    output ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
    input  ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto a single RAM port,
// data first, with a bounded wait and a sticky timeout flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus,
  output logic          err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  mem_op_e           r_op;
  req_src_e          r_src;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic w_dreq;
  logic w_access;
  logic w_expire;

  assign w_dreq   = bus.dREN | bus.dWEN;
  assign w_access = (r_state == DACC) || (r_state == IACC);
  // Last permitted wait cycle passes without ram_ready: abandon the access.
  assign w_expire = w_access && !bus.ram_ready && (r_cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_dreq) begin
          w_state_nxt = DACC;
        end else if (bus.iREN) begin
          w_state_nxt = IACC;
        end
      end
      DACC, IACC: begin
        if (bus.ram_ready) begin
          w_state_nxt = DONE;
        end else if (w_expire) begin
          w_state_nxt = IDLE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op    <= OP_READ;
      r_src   <= SRC_INSTR;
      r_addr  <= '0;
      r_store <= '0;
      r_iload <= '0;
      r_dload <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (w_dreq) begin
          r_src   <= SRC_DATA;
          r_op    <= bus.dWEN ? OP_WRITE : OP_READ;
          r_addr  <= bus.daddr;
          r_store <= bus.dstore;
          r_cnt   <= '0;
        end else if (bus.iREN) begin
          r_src  <= SRC_INSTR;
          r_op   <= OP_READ;
          r_addr <= bus.iaddr;
          r_cnt  <= '0;
        end
      end
      if (w_access && bus.ram_ready) begin
        if (r_state == IACC) begin
          r_iload <= bus.ram_load;
        end else if (r_op == OP_READ) begin
          r_dload <= bus.ram_load;
        end
      end
      if (w_access && !bus.ram_ready && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_expire) begin
        r_err <= 1'b1;
      end
    end
  end

  // Hits are qualified by the live request so a withdrawn request gets none.
  always_comb begin
    bus.ram_ren   = 1'b0;
    bus.ram_wen   = 1'b0;
    bus.ram_addr  = r_addr;
    bus.ram_store = r_store;
    bus.ihit      = 1'b0;
    bus.dhit      = 1'b0;
    case (r_state)
      DACC: begin
        bus.ram_ren = (r_op == OP_READ);
        bus.ram_wen = (r_op == OP_WRITE);
      end
      IACC: bus.ram_ren = 1'b1;
      DONE: begin
        bus.ihit = (r_src == SRC_INSTR) && bus.iREN;
        bus.dhit = (r_src == SRC_DATA) && w_dreq;
      end
      default: ;
    endcase
  end

  assign bus.iload = r_iload;
  assign bus.dload = r_dload;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// compared against the DUT on every falling clock edge.
module tb_mem_arbiter;

  localparam int unsigned TO = 15;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic err;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.TIMEOUT(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus),
    .err (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, tracked as flags and a wait tally.
  bit          m_valid = 1'b0;
  bit          m_access, m_done, m_data, m_write, m_err;
  int          m_waited;
  logic [31:0] m_addr, m_store, m_iload, m_dload;
  logic        e_ren, e_wen, e_ihit, e_dhit;

  always @(negedge CLK) begin
    if (m_valid) begin
      e_ren  = m_access && !(m_data && m_write);
      e_wen  = m_access && m_data && m_write;
      e_ihit = m_done && !m_data && bus.iREN;
      e_dhit = m_done && m_data && (bus.dREN || bus.dWEN);
      check("ram_ren", 64'(bus.ram_ren), 64'(e_ren));
      check("ram_wen", 64'(bus.ram_wen), 64'(e_wen));
      if (e_ren || e_wen) check("ram_addr", 64'(bus.ram_addr), 64'(m_addr));
      if (e_wen) check("ram_store", 64'(bus.ram_store), 64'(m_store));
      check("ihit", 64'(bus.ihit), 64'(e_ihit));
      check("dhit", 64'(bus.dhit), 64'(e_dhit));
      check("iload", 64'(bus.iload), 64'(m_iload));
      check("dload", 64'(bus.dload), 64'(m_dload));
      check("err", 64'(err), 64'(m_err));
    end
    if (RST) begin
      m_valid = 1'b1;
      m_access = 1'b0; m_done = 1'b0; m_data = 1'b0; m_write = 1'b0; m_err = 1'b0;
      m_waited = 0;
      m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
    end else if (m_access) begin
      if (bus.ram_ready) begin
        if (!m_data) m_iload = bus.ram_load;
        else if (!m_write) m_dload = bus.ram_load;
        m_access = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_waited++;
        if (m_waited >= int'(TO)) begin
          m_err    = 1'b1;
          m_access = 1'b0;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (bus.dREN || bus.dWEN) begin
      m_data = 1'b1; m_write = bus.dWEN;
      m_addr = bus.daddr; m_store = bus.dstore;
      m_waited = 0; m_access = 1'b1;
    end else if (bus.iREN) begin
      m_data = 1'b0; m_write = 1'b0;
      m_addr = bus.iaddr;
      m_waited = 0; m_access = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_ren"}, 64'(bus.ram_ren), 64'd0);
    check({tag, "_ram_wen"}, 64'(bus.ram_wen), 64'd0);
    check({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'd0);
    check({tag, "_ram_store"}, 64'(bus.ram_store), 64'd0);
    check({tag, "_ihit"}, 64'(bus.ihit), 64'd0);
    check({tag, "_dhit"}, 64'(bus.dhit), 64'd0);
    check({tag, "_iload"}, 64'(bus.iload), 64'd0);
    check({tag, "_dload"}, 64'(bus.dload), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n_strobe;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ram_ready = 1'b0; bus.ram_load = '0;

    repeat (3) cyc();
    check_all_zero("reset");
    RST = 1'b0;
    cyc();

    // Single data read, RAM ready on the second access cycle.
    bus.dREN = 1'b1; bus.daddr = 32'h40;
    cyc();
    check("rd_ren", 64'(bus.ram_ren), 64'd1);
    check("rd_addr", 64'(bus.ram_addr), 64'h40);
    cyc();
    bus.ram_ready = 1'b1; bus.ram_load = 32'hDEADBEEF;
    cyc();
    bus.ram_ready = 1'b0;
    check("rd_dhit", 64'(bus.dhit), 64'd1);
    check("rd_dload", 64'(bus.dload), 64'hDEADBEEF);
    cyc();
    bus.dREN = 1'b0;
    check("rd_dhit_pulse", 64'(bus.dhit), 64'd0);
    cyc();

    // Simultaneous fetch and write: write goes first.
    bus.iREN = 1'b1; bus.iaddr = 32'h100;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
    cyc();
    check("sim_wen", 64'(bus.ram_wen), 64'd1);
    check("sim_ren_low", 64'(bus.ram_ren), 64'd0);
    check("sim_addr", 64'(bus.ram_addr), 64'h80);
    check("sim_store", 64'(bus.ram_store), 64'h1234);
    bus.ram_ready = 1'b1; bus.ram_load = 32'h0BAD0BAD;
    cyc();
    bus.ram_ready = 1'b0;
    check("sim_dhit", 64'(bus.dhit), 64'd1);
    check("sim_ihit_early", 64'(bus.ihit), 64'd0);
    cyc();
    bus.dWEN = 1'b0;
    check("sim_dload_kept", 64'(bus.dload), 64'hDEADBEEF);
    cyc();
    check("sim_iren", 64'(bus.ram_ren), 64'd1);
    check("sim_iaddr", 64'(bus.ram_addr), 64'h100);
    bus.ram_ready = 1'b1; bus.ram_load = 32'hCAFE0001;
    cyc();
    bus.ram_ready = 1'b0;
    check("sim_ihit", 64'(bus.ihit), 64'd1);
    check("sim_iload", 64'(bus.iload), 64'hCAFE0001);
    cyc();
    bus.iREN = 1'b0;
    cyc();

    // Fetch withdrawn mid-access: load updates, hit suppressed.
    bus.iREN = 1'b1; bus.iaddr = 32'h200;
    cyc();
    cyc();
    bus.iREN = 1'b0; bus.ram_ready = 1'b1; bus.ram_load = 32'h5;
    cyc();
    bus.ram_ready = 1'b0;
    check("wd_ihit", 64'(bus.ihit), 64'd0);
    check("wd_iload", 64'(bus.iload), 64'h5);
    cyc();

    // RAM never ready: access abandoned after TIMEOUT wait cycles.
    bus.dREN = 1'b1; bus.daddr = 32'h300;
    n_strobe = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (bus.ram_ren) n_strobe++;
      else break;
    end
    bus.dREN = 1'b0;
    check("to_strobes", 64'(n_strobe), 64'd15);
    check("to_err", 64'(err), 64'd1);
    check("to_dhit", 64'(bus.dhit), 64'd0);
    bus.iREN = 1'b1; bus.iaddr = 32'h400;
    cyc();
    check("to_next_ren", 64'(bus.ram_ren), 64'd1);
    bus.ram_ready = 1'b1; bus.ram_load = 32'h77;
    cyc();
    bus.ram_ready = 1'b0;
    check("to_next_ihit", 64'(bus.ihit), 64'd1);
    check("to_next_iload", 64'(bus.iload), 64'h77);
    check("to_err_sticky", 64'(err), 64'd1);
    cyc();
    bus.iREN = 1'b0;
    cyc();

    // Reset in the middle of a data access.
    bus.dREN = 1'b1; bus.daddr = 32'h500; bus.dstore = 32'hAA;
    cyc();
    check("rst_pre_ren", 64'(bus.ram_ren), 64'd1);
    RST = 1'b1;
    cyc();
    check_all_zero("midrst");
    RST = 1'b0; bus.dREN = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
